// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: registered single-cycle arithmetic/logic/compare ops and
// an iterative 1-bit-per-cycle shifter, with valid/ready handshakes on both sides.
module alu_exec_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            alu_ctrl,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zero,
    output logic                  illegal
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [1:0] K_SLL = 2'd0;
    localparam logic [1:0] K_SRL = 2'd1;
    localparam logic [1:0] K_SRA = 2'd2;

    localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  zero_q, zero_d;
    logic                  illegal_q, illegal_d;
    logic [SHAMT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]            kind_q, kind_d;
    logic                  sign_q, sign_d;

    logic [SHAMT_W-1:0]    shamt;
    logic [1:0]            kind;
    logic                  accept;
    logic                  lt_s;
    logic                  lt_u;

    // One 1-bit shift step; SRA fills with the sign captured from the original operand.
    function automatic logic [DATA_WIDTH-1:0] step1(
        input logic [DATA_WIDTH-1:0] v,
        input logic [1:0]            k,
        input logic                  s
    );
        case (k)
            K_SLL:   return {v[DATA_WIDTH-2:0], 1'b0};
            K_SRL:   return {1'b0, v[DATA_WIDTH-1:1]};
            default: return {s, v[DATA_WIDTH-1:1]};
        endcase
    endfunction

    assign shamt     = src_b[SHAMT_W-1:0];
    assign kind      = (alu_ctrl == 4'd7) ? K_SLL :
                       (alu_ctrl == 4'd8) ? K_SRL : K_SRA;
    assign in_ready  = (state_q == S_IDLE) |
                       ((state_q == S_DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign lt_s      = $signed(src_a) < $signed(src_b);
    assign lt_u      = src_a < src_b;
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

    // Next-state: accept a new op, step an in-flight shift, or retire a held result.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        kind_d    = kind_q;
        sign_d    = sign_q;
        if (accept) begin
            state_d   = S_DONE;
            illegal_d = 1'b0;
            cnt_d     = '0;
            kind_d    = kind;
            sign_d    = src_a[DATA_WIDTH-1];
            case (alu_ctrl)
                4'd0: result_d = src_a + src_b;
                4'd1: result_d = src_a - src_b;
                4'd2: result_d = src_a & src_b;
                4'd3: result_d = src_a | src_b;
                4'd4: result_d = src_a ^ src_b;
                4'd5: result_d = {{(DATA_WIDTH-1){1'b0}}, lt_s};
                4'd6: result_d = {{(DATA_WIDTH-1){1'b0}}, lt_u};
                4'd7, 4'd8, 4'd9: begin
                    if (shamt == '0) begin
                        result_d = src_a;
                    end else begin
                        result_d = step1(src_a, kind, src_a[DATA_WIDTH-1]);
                        cnt_d    = shamt - CNT_ONE;
                        if (shamt != CNT_ONE) begin
                            state_d = S_SHIFT;
                        end
                    end
                end
                default: begin
                    result_d  = '0;
                    illegal_d = 1'b1;
                end
            endcase
            zero_d = (result_d == '0);
        end else if (state_q == S_SHIFT) begin
            result_d = step1(result_q, kind_q, sign_q);
            zero_d   = (result_d == '0);
            cnt_d    = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
                state_d = S_DONE;
            end
        end else if ((state_q == S_DONE) && out_ready) begin
            state_d = S_IDLE;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
            kind_q    <= K_SLL;
            sign_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
            kind_q    <= kind_d;
            sign_q    <= sign_d;
        end
    end

endmodule
